// File: rtl/dmem_mmio_if.sv
// -----------------------------------------------------------------------------
// dmem_mmio_if
//   The data-memory port of the single-cycle RV32I core.
//
//   Signals:
//     memwrite  : store strobe. The write is performed at the next rising edge.
//     aluout    : byte address. Bits [1:0] are ignored, so every access is a
//                 full word.
//     writedata : store data.
//     readdata  : load data. It is combinational from aluout.
//
//   Modports:
//     master : the core side. It drives memwrite, aluout and writedata.
//     slave  : the memory/MMIO responder. It drives readdata.
// -----------------------------------------------------------------------------
interface dmem_mmio_if;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output memwrite,
        output aluout,
        output writedata,
        input  readdata
    );

    modport slave (
        input  memwrite,
        input  aluout,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
//   Data-side responder for the single-cycle RV32I core. It contains:
//     - a word-addressed RAM (aluout[31] == 0),
//     - an MMIO window (aluout[31] == 1) holding:
//         0x8000_0000 CONSOLE : write pushes writedata[7:0]; reads return 0.
//         0x8000_0004 STATUS  : {16'b0, count[7:0], 5'b0, ovf, empty, full}.
//                               Read-only.
//         0x8000_0008 CYCLE   : free-running counter. A write loads it.
//         0x8000_000C TOHOST  : a write sets halt and stores halt_code.
//                               A read returns halt_code.
//
//   Ports:
//     clk, reset  : sole clock; synchronous active-high reset.
//     bus         : core data port (slave side of dmem_mmio_if).
//     tx_valid    : console FIFO is non-empty.
//     tx_data     : byte at the FIFO head.
//     tx_ready    : consumer takes the head when tx_valid is also high.
//     halt        : sticky. Set by a TOHOST write; cleared only by reset.
//     halt_code   : last value written to TOHOST.
// -----------------------------------------------------------------------------
module dmem_mmio #(
    parameter int DEPTH_WORDS = 256,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    dmem_mmio_if.slave        bus,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              halt,
    output logic [31:0]       halt_code
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;   // count must be able to hold FIFO_DEPTH

    // One-hot address decode of the current access.
    typedef struct packed {
        logic ram;
        logic console;
        logic status;
        logic cycle;
        logic tohost;
    } dec_t;

    dec_t dec;

    always_comb begin
        dec = '0;
        if (!bus.aluout[31]) begin
            dec.ram = 1'b1;
        end else begin
            // The whole of aluout[30:2] takes part in the compare, so that
            // nothing in the MMIO window aliases onto the registers.
            case (bus.aluout[30:2])
                29'd0:   dec.console = 1'b1;
                29'd1:   dec.status  = 1'b1;
                29'd2:   dec.cycle   = 1'b1;
                29'd3:   dec.tohost  = 1'b1;
                default: ;
            endcase
        end
    end

    // Byte-lane bits are dropped because every access is a full word.
    logic unused_addr;
    assign unused_addr = ^bus.aluout[1:0];

    // ------------------------------------------------------------------
    // RAM: combinational read, synchronous write, no reset.
    // Upper address bits alias onto the same words.
    // ------------------------------------------------------------------
    logic [31:0]   ram [DEPTH_WORDS];
    logic [AW-1:0] ram_idx;

    assign ram_idx = bus.aluout[AW+1:2];

    always_ff @(posedge clk) begin
        if (!reset && bus.memwrite && dec.ram)
            ram[ram_idx] <= bus.writedata;
    end

    // ------------------------------------------------------------------
    // Console FIFO: circular buffer with head/tail pointers and a count.
    // ------------------------------------------------------------------
    logic [FIFO_DEPTH-1:0][7:0] fifo_q;
    logic [FW-1:0]              head_q, tail_q;
    logic [CW-1:0]              count_q;
    logic                       ovf_q;
    logic                       fifo_full, fifo_empty;
    logic                       push_req, push_ok, pop;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign tx_valid   = !fifo_empty;
    assign tx_data    = fifo_q[head_q];

    assign pop      = tx_valid && tx_ready;
    assign push_req = bus.memwrite && dec.console;
    // A pop in the same cycle frees the slot, so a push to a full FIFO
    // still lands. Both pointers then advance and the count holds.
    assign push_ok  = push_req && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (push_ok)
                tail_q <= tail_q + FW'(1);
            if (pop)
                head_q <= head_q + FW'(1);
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && !push_ok)
                ovf_q <= 1'b1;
        end
    end

    // The storage is left unreset. Entries are only visible through the
    // count and the pointers.
    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            fifo_q[tail_q] <= bus.writedata[7:0];
    end

    // ------------------------------------------------------------------
    // Cycle counter: a load wins over the increment. The count is frozen
    // while halted, but it can still be loaded.
    // ------------------------------------------------------------------
    logic [31:0] cycle_q;

    always_ff @(posedge clk) begin
        if (reset)
            cycle_q <= '0;
        else if (bus.memwrite && dec.cycle)
            cycle_q <= bus.writedata;
        else if (!halt)
            cycle_q <= cycle_q + 32'd1;
    end

    // ------------------------------------------------------------------
    // Halt / tohost
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            halt      <= 1'b0;
            halt_code <= '0;
        end else if (bus.memwrite && dec.tohost) begin
            halt      <= 1'b1;
            halt_code <= bus.writedata;
        end
    end

    // ------------------------------------------------------------------
    // Read mux. It is live even during reset and shows registered state
    // only.
    // ------------------------------------------------------------------
    logic [31:0] status_word;

    assign status_word = {16'd0, 8'(count_q), 5'd0, ovf_q, fifo_empty, fifo_full};

    always_comb begin
        bus.readdata = '0;
        unique case (1'b1)
            dec.ram:    bus.readdata = ram[ram_idx];
            dec.status: bus.readdata = status_word;
            dec.cycle:  bus.readdata = cycle_q;
            dec.tohost: bus.readdata = halt_code;
            default:    bus.readdata = '0;   // CONSOLE and unmapped
        endcase
    end

endmodule

// File: tb/tb_dmem_mmio.sv
// -----------------------------------------------------------------------------
// tb_dmem_mmio
//   Directed vectors for dmem_mmio. Every expected value is a hand-computed
//   constant. Inputs change 1 time unit after the rising edge, and outputs
//   are sampled before the next rising edge.
// -----------------------------------------------------------------------------
module tb_dmem_mmio;

    localparam logic [31:0] A_CONSOLE = 32'h8000_0000;
    localparam logic [31:0] A_STATUS  = 32'h8000_0004;
    localparam logic [31:0] A_CYCLE   = 32'h8000_0008;
    localparam logic [31:0] A_TOHOST  = 32'h8000_000C;

    logic        clk = 1'b0;
    logic        reset;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        halt;
    logic [31:0] halt_code;

    int n_checks = 0;
    int n_errors = 0;

    dmem_mmio_if bus ();

    dmem_mmio #(.DEPTH_WORDS(256), .FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .halt      (halt),
        .halt_code (halt_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        bus.memwrite  = 1'b1;
        bus.aluout    = addr;
        bus.writedata = data;
        tick();
        bus.memwrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        bus.aluout = addr;
        #1;
        check(tag, bus.readdata, exp);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.memwrite = 1'b0;
        tx_ready     = 1'b0;
        tick();
        reset        = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.memwrite  = 1'b0;
        bus.aluout    = '0;
        bus.writedata = '0;
        tx_ready      = 1'b0;
        reset         = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_halt", 32'(halt), 32'd0);
        check("rst_halt_code", halt_code, 32'd0);
        rd("rst_status", A_STATUS, 32'h0000_0002);
        rd("rst_cycle", A_CYCLE, 32'd0);

        // RAM: store, byte-offset alias, neighbour word, read-before-write
        wr(32'h0000_0014, 32'h1234_5678);
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
        rd("ram_14", 32'h0000_0014, 32'h1234_5678);
        rd("ram_alias", 32'h0000_0410, 32'hDEAD_BEEF);
        bus.memwrite  = 1'b1;
        bus.aluout    = 32'h0000_0010;
        bus.writedata = 32'hCAFE_F00D;
        #1;
        check("ram_rd_old", bus.readdata, 32'hDEAD_BEEF);
        tick();
        bus.memwrite = 1'b0;
        rd("ram_rd_new", 32'h0000_0010, 32'hCAFE_F00D);

        // Console order
        do_reset();
        bus.memwrite  = 1'b1;
        bus.aluout    = A_CONSOLE;
        bus.writedata = 32'h141;
        #1;
        check("con_no_comb_valid", 32'(tx_valid), 32'd0);
        tick();
        bus.memwrite = 1'b0;
        check("con_first_valid", 32'(tx_valid), 32'd1);
        check("con_first_data", 32'(tx_data), 32'h41);
        wr(A_CONSOLE, 32'h42);
        wr(A_CONSOLE, 32'h43);
        rd("con_status3", A_STATUS, 32'h0000_0300);
        rd("con_read0", A_CONSOLE, 32'd0);
        check("con_head", 32'(tx_data), 32'h41);
        tx_ready = 1'b1;
        tick();
        check("con_d1", 32'(tx_data), 32'h42);
        tick();
        check("con_d2", 32'(tx_data), 32'h43);
        tick();
        tx_ready = 1'b0;
        check("con_drained", 32'(tx_valid), 32'd0);
        rd("con_status_empty", A_STATUS, 32'h0000_0002);

        // Overflow and push+pop while full
        do_reset();
        for (int i = 0; i < 5; i++) wr(A_CONSOLE, 32'h10 + 32'(i));
        rd("ovf_status", A_STATUS, 32'h0000_0405);
        check("ovf_head", 32'(tx_data), 32'h10);
        tx_ready = 1'b1;
        wr(A_CONSOLE, 32'h55);
        tx_ready = 1'b0;
        rd("ovf_pushpop_status", A_STATUS, 32'h0000_0405);
        tx_ready = 1'b1;
        check("ovf_d0", 32'(tx_data), 32'h11);
        tick();
        check("ovf_d1", 32'(tx_data), 32'h12);
        tick();
        check("ovf_d2", 32'(tx_data), 32'h13);
        tick();
        check("ovf_d3", 32'(tx_data), 32'h55);
        tick();
        tx_ready = 1'b0;
        check("ovf_empty_valid", 32'(tx_valid), 32'd0);
        rd("ovf_sticky", A_STATUS, 32'h0000_0006);
        wr(A_STATUS, 32'hFFFF_FFFF);
        rd("status_ro", A_STATUS, 32'h0000_0006);

        // Counter
        do_reset();
        rd("cyc0", A_CYCLE, 32'd0);
        tick();
        rd("cyc1", A_CYCLE, 32'd1);
        tick();
        rd("cyc2", A_CYCLE, 32'd2);
        wr(A_CYCLE, 32'hFFFF_FFFE);
        rd("cyc_ld", A_CYCLE, 32'hFFFF_FFFE);
        tick();
        rd("cyc_max", A_CYCLE, 32'hFFFF_FFFF);
        tick();
        rd("cyc_wrap", A_CYCLE, 32'h0000_0000);

        // Halt
        wr(A_CYCLE, 32'd100);
        wr(A_TOHOST, 32'h1);          // counter still steps on this edge
        check("halt_set", 32'(halt), 32'd1);
        check("halt_code1", halt_code, 32'h1);
        rd("halt_frozen_a", A_CYCLE, 32'd101);
        tick();
        rd("halt_frozen_b", A_CYCLE, 32'd101);
        rd("tohost_rd", A_TOHOST, 32'h1);
        wr(A_TOHOST, 32'h7);
        check("halt_code7", halt_code, 32'h7);
        check("halt_sticky", 32'(halt), 32'd1);
        wr(A_CYCLE, 32'h55);
        rd("halt_cyc_ld", A_CYCLE, 32'h55);
        tick();
        rd("halt_cyc_hold", A_CYCLE, 32'h55);
        wr(A_CONSOLE, 32'h99);        // FIFO still works while halted
        check("halt_fifo_push", 32'(tx_data), 32'h99);
        for (int i = 0; i < 4; i++) wr(A_CONSOLE, 32'h0);
        rd("halt_fifo_ovf", A_STATUS, 32'h0000_0405);
        do_reset();
        check("rst2_halt", 32'(halt), 32'd0);
        check("rst2_halt_code", halt_code, 32'd0);
        check("rst2_tx_valid", 32'(tx_valid), 32'd0);
        rd("rst2_cycle", A_CYCLE, 32'd0);
        rd("rst2_status", A_STATUS, 32'h0000_0002);

        // Unmapped
        wr(32'h8000_0100, 32'h1234);
        rd("unmap_rd", 32'h8000_0100, 32'd0);
        rd("unmap_10", 32'h8000_0010, 32'd0);
        rd("unmap_status", A_STATUS, 32'h0000_0002);
        rd("unmap_cycle", A_CYCLE, 32'd1);
        check("unmap_halt", 32'(halt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_mmio.md
# dmem_mmio

Data-side responder for the single-cycle RV32I core's memory port. It services the core's `memwrite` / `aluout` / `writedata` / `readdata` interface with a word-addressed data RAM plus a small MMIO window containing:
- a console TX FIFO with a valid/ready drain port,
- a free-running cycle counter,
- a tohost halt register.

It sits beside the core in the top-level SoC/testbench, opposite the core's data-memory master interface.

## Interface
Parameters:
- `DEPTH_WORDS`, 256, RAM size in 32-bit words; power of two.
- `FIFO_DEPTH`, 4, console FIFO entries; power of two, ≥2.

Ports:
- `clk`  input  1  sole clock; all state updates on rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `memwrite`  input  1  core store strobe; write performed at the next rising edge.
- `aluout`  input  32  byte address from the core.
- `writedata`  input  32  store data.
- `readdata`  output  32  load data; combinational from `aluout` and current state.
- `tx_valid`  output  1  console FIFO non-empty.
- `tx_data`  output  8  FIFO head byte.
- `tx_ready`  input  1  consumer accepts head when high together with `tx_valid`.
- `halt`  output  1  sticky; set by a tohost write.
- `halt_code`  output  32  value written to tohost.

## Operation
Address decode; `aluout[1:0]` is ignored, so all accesses are full-word:
- `aluout[31]==0`: RAM, index `aluout[log2(DEPTH_WORDS)+1:2]`. Upper address bits alias.
- 0x8000_0000 CONSOLE
  - Write: push `writedata[7:0]`.
  - Read: returns 0.
- 0x8000_0004 STATUS (read-only; writes ignored)
  - bit0 full.
  - bit1 empty.
  - bit2 overflow (sticky).
  - bits[15:8] occupancy count.
  - Other bits 0.
- 0x8000_0008 CYCLE
  - Read: counter.
  - Write: loads `writedata`.
- 0x8000_000C TOHOST
  - Read: `halt_code`.
  - Write: `halt`←1, `halt_code`←`writedata`.
- Any other address with bit31 set: read returns 0; write ignored.

RAM:
- Single-port, combinational read, synchronous write.
- RAM contents are not cleared by `reset`.

Console FIFO (circular buffer; head/tail pointers plus count):
- Push: `memwrite` to CONSOLE.
- Pop: `tx_valid && tx_ready`.
- `tx_valid = (count != 0)`; `tx_data` = entry at head.
- A push is accepted if `count < FIFO_DEPTH`, or if a pop occurs in the same cycle.
  - Push+pop when full: count unchanged; both pointers advance.
- A push to a full FIFO without a same-cycle pop is dropped. Overflow is set and stays set until `reset`.
- Pop when empty: impossible, since `tx_valid=0`.
- Pointers wrap modulo `FIFO_DEPTH`.

Cycle counter:
- 32-bit; increments by 1 each cycle, wrapping 0xFFFF_FFFF→0.
- A CYCLE write takes priority over the increment in that cycle.
- Frozen while `halt=1`. A CYCLE write still loads it while frozen.

Halt:
- Once set, `halt` stays set until `reset`.
- Later TOHOST writes update `halt_code` only.
- RAM and FIFO remain fully operational while halted.

## Timing
- Reads have zero latency: `readdata` is valid in the same cycle as `aluout`.
- A write at edge N is visible to reads in cycle N+1.
- A read and write to the same address in one cycle returns the old value.
- A byte pushed at edge N:
  - appears on `tx_data` with `tx_valid=1` from cycle N+1 if the FIFO was empty;
  - otherwise appears once it reaches the head.
- The FIFO has no combinational path from `memwrite` to `tx_valid`.
- STATUS reflects registered state. A push in the current cycle is not shown until the next cycle.
- Reset values (after an edge with `reset=1`): `tx_valid` 0, `halt` 0, `halt_code` 0, counter 0, FIFO count 0, overflow 0.
- `reset` has priority over every simultaneous write or pop. A reset mid-drain discards FIFO contents.
- During `reset`, `readdata` still decodes combinationally. MMIO reads return current register values.

## Test plan
- RAM: store 0xDEADBEEF to 0x0000_0010, then load 0x0000_0010 and 0x0000_0013 on the next cycle → both return 0xDEADBEEF. Load of 0x0000_0014 is unaffected.
- Console order: `tx_ready=0`, write 0x141, 0x42, 0x43 to CONSOLE.
  - Expected: STATUS=0x0000_0300; `tx_data`=0x41.
  - Raise `tx_ready` → 0x41, 0x42, 0x43 over 3 cycles, then `tx_valid=0` and STATUS=0x0000_0002.
- Overflow: `tx_ready=0`, 5 pushes with depth 4 → 5th dropped, STATUS=0x0000_0405.
  - Then push+pop in the same cycle while full → count stays 4; new byte lands at tail.
- Counter: after reset, CYCLE reads 0, 1, 2 on successive cycles.
  - Write 0xFFFF_FFFE → reads 0xFFFF_FFFE, 0xFFFF_FFFF, 0x0000_0000.
- Halt: write 0x1 to TOHOST → `halt=1` and `halt_code=1` next cycle; CYCLE frozen; TOHOST reads 0x1.
  - Write 0x7 → `halt_code=7`, `halt` stays 1.
  - Assert `reset` for 1 cycle → `halt=0`, counter 0, FIFO empty, overflow 0.
- Unmapped: write to 0x8000_0100, then read it → 0. No state change in FIFO, counter, or halt.
